// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames 1 start, 8 data (LSB first), 1 stop bit from a
// synchronized line, sampling each bit at mid-period, with done/error pulses.
module uart_rx_ctrl #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_sync,
    input  logic       neg_rx_int,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int HALF  = BAUD_DIV / 2;
    localparam int CNT_W = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic [7:0]       rx_data_r, rx_data_s;
    logic             rx_done_r, rx_done_s;
    logic             frame_err_r, frame_err_s;
    logic             rx_busy_r, rx_busy_s;
    logic             mid_s;
    logic             last_s;

    assign mid_s  = (cnt_r == CNT_HALF);
    assign last_s = (cnt_r == CNT_LAST);

    // Next-state, counter, shift and output-pulse logic
    always_comb begin
        state_s     = state_r;
        cnt_s       = last_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        rx_data_s   = rx_data_r;
        rx_done_s   = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (neg_rx_int) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // A high line at mid start bit was only a glitch
                if (mid_s && rx_sync) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (last_s) begin
                    state_s   = ST_DATA;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (mid_s) begin
                    shift_s = {rx_sync, shift_r[7:1]};
                end else begin
                    shift_s = shift_r;
                end
                if (last_s) begin
                    if (bit_idx_r == 3'd7) begin
                        state_s   = ST_STOP;
                        bit_idx_s = 3'd0;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_idx_s = bit_idx_r;
                end
            end
            ST_STOP: begin
                // Leave at the stop sample so a new start edge late in the stop bit is caught
                if (mid_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    if (rx_sync) begin
                        rx_done_s = 1'b1;
                        rx_data_s = shift_r;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = CNT_ZERO;
                bit_idx_s = 3'd0;
            end
        endcase
        rx_busy_s = (state_s != ST_IDLE) | rx_done_s | frame_err_s;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
            rx_busy_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
            rx_data_r   <= rx_data_s;
            rx_done_r   <= rx_done_s;
            frame_err_r <= frame_err_s;
            rx_busy_r   <= rx_busy_s;
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_done   = rx_done_r;
    assign frame_err = frame_err_r;
    assign rx_busy   = rx_busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at BAUD_DIV=8: frame timing, framing error,
// false start, back-to-back frames, ignored spurious edges and mid-frame reset.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_sync;
    logic       neg_rx_int;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int both_n = 0;
    int t0;
    int done_q[$];
    int err_q[$];
    logic [7:0] data_q[$];

    uart_rx_ctrl #(.BAUD_DIV(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_sync    (rx_sync),
        .neg_rx_int (neg_rx_int),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log output pulses with the cycle they appear in
    always @(negedge clk) begin
        if (rx_done) begin
            done_q.push_back(cyc);
            data_q.push_back(rx_data);
        end
        if (frame_err) err_q.push_back(cyc);
        if (rx_done && frame_err) both_n = both_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_sync    = 1'b1;
        neg_rx_int = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        done_q.delete();
        err_q.delete();
        data_q.delete();
    endtask

    function automatic logic line_bit(input logic [7:0] b, input logic stop_b, input int c);
        int k;
        k = c / 8;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else if (k == 9) return stop_b;
        else return 1'b1;
    endfunction

    // Drive cycles 0..ncyc-1 of a frame; start edge at cycle 0, optional spurious edges
    task automatic drive_frame(input logic [7:0] b, input logic stop_b, input int ncyc,
                               input int spur_a, input int spur_b);
        for (int c = 0; c < ncyc; c++) begin
            rx_sync    = line_bit(b, stop_b, c);
            neg_rx_int = (c == 0) || (c == spur_a) || (c == spur_b);
            tick();
        end
        rx_sync    = 1'b1;
        neg_rx_int = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_sync    = 1'b1;
        neg_rx_int = 1'b0;
        tick();
        tick();
        check_eq("rst_data", rx_data, 32'h00);
        check_eq("rst_done", rx_done, 32'h0);
        check_eq("rst_err", frame_err, 32'h0);
        check_eq("rst_busy", rx_busy, 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Good frame 0xA5, with busy/done checks around the stop sample
        clear_log();
        t0 = cyc;
        check_eq("a5_busy_t0", rx_busy, 32'h0);
        drive_frame(8'hA5, 1'b1, 1, -1, -1);
        check_eq("a5_busy_t1", rx_busy, 32'h1);
        drive_frame(8'hA5, 1'b1, 0, -1, -1);
        for (int c = 1; c < 78; c++) begin
            rx_sync = line_bit(8'hA5, 1'b1, c);
            tick();
        end
        check_eq("a5_done_t78", rx_done, 32'h1);
        check_eq("a5_busy_t78", rx_busy, 32'h1);
        tick();
        check_eq("a5_busy_t79", rx_busy, 32'h0);
        check_eq("a5_done_t79", rx_done, 32'h0);
        idle(5);
        check_eq("a5_ndone", done_q.size(), 32'd1);
        if (done_q.size() > 0) begin
            check_eq("a5_done_cyc", done_q[0], t0 + 78);
            check_eq("a5_pulse_data", data_q[0], 32'hA5);
        end
        check_eq("a5_nerr", err_q.size(), 32'd0);
        check_eq("a5_data", rx_data, 32'hA5);

        // 0x3C with stop bit low
        clear_log();
        t0 = cyc;
        drive_frame(8'h3C, 1'b0, 80, -1, -1);
        idle(5);
        check_eq("3c_nerr", err_q.size(), 32'd1);
        if (err_q.size() > 0) check_eq("3c_err_cyc", err_q[0], t0 + 78);
        check_eq("3c_ndone", done_q.size(), 32'd0);
        check_eq("3c_data_kept", rx_data, 32'hA5);

        // Two-cycle glitch: false start
        clear_log();
        for (int c = 0; c < 12; c++) begin
            rx_sync    = (c < 2) ? 1'b0 : 1'b1;
            neg_rx_int = (c == 0);
            if (c == 5) check_eq("glitch_busy5", rx_busy, 32'h1);
            if (c == 6) check_eq("glitch_busy6", rx_busy, 32'h0);
            tick();
        end
        idle(80);
        check_eq("glitch_ndone", done_q.size(), 32'd0);
        check_eq("glitch_nerr", err_q.size(), 32'd0);
        check_eq("glitch_data", rx_data, 32'hA5);

        // Back-to-back 0x00 then 0xFF, second edge right after first stop sample
        clear_log();
        t0 = cyc;
        drive_frame(8'h00, 1'b1, 78, -1, -1);
        drive_frame(8'hFF, 1'b1, 80, -1, -1);
        idle(5);
        check_eq("b2b_ndone", done_q.size(), 32'd2);
        if (done_q.size() == 2) begin
            check_eq("b2b_cyc0", done_q[0], t0 + 78);
            check_eq("b2b_data0", data_q[0], 32'h00);
            check_eq("b2b_cyc1", done_q[1], t0 + 156);
            check_eq("b2b_data1", data_q[1], 32'hFF);
        end
        check_eq("b2b_nerr", err_q.size(), 32'd0);

        // Spurious edges during data bits
        clear_log();
        t0 = cyc;
        drive_frame(8'h96, 1'b1, 80, 20, 45);
        idle(5);
        check_eq("spur_ndone", done_q.size(), 32'd1);
        if (done_q.size() > 0) begin
            check_eq("spur_cyc", done_q[0], t0 + 78);
            check_eq("spur_data", data_q[0], 32'h96);
        end
        check_eq("spur_nerr", err_q.size(), 32'd0);

        // Asynchronous reset mid-frame
        clear_log();
        drive_frame(8'h5A, 1'b1, 40, -1, -1);
        check_eq("mid_busy", rx_busy, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data", rx_data, 32'h00);
        check_eq("arst_busy", rx_busy, 32'h0);
        check_eq("arst_done", rx_done, 32'h0);
        check_eq("arst_err", frame_err, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(100);
        check_eq("arst_ndone", done_q.size(), 32'd0);
        check_eq("arst_nerr", err_q.size(), 32'd0);
        check_eq("arst_busy_idle", rx_busy, 32'h0);

        clear_log();
        t0 = cyc;
        drive_frame(8'h5A, 1'b1, 80, -1, -1);
        idle(5);
        check_eq("5a_ndone", done_q.size(), 32'd1);
        if (done_q.size() > 0) check_eq("5a_cyc", done_q[0], t0 + 78);
        check_eq("5a_data", rx_data, 32'h5A);
        check_eq("5a_nerr", err_q.size(), 32'd0);

        check_eq("exclusive", both_n, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
